// File: rtl/mcp_rx_multibit_pkg.sv
// Shared definitions for the multicycle-path multibit receiver:
// FSM state encodings and the minimum request synchronizer depth.
package mcp_rx_multibit_pkg;

    localparam int MIN_NB_SYNC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/mcp_rx_multibit_sync_bit_chain.sv
// sync_bit_chain: 1-bit NB_SYNC-stage synchronizer with synchronous
// active-high reset. The same block serves the source side for the ack.
module sync_bit_chain #(
    parameter int NB_SYNC = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [NB_SYNC-1:0] chain_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            chain_r <= {NB_SYNC{1'b0}};
        end else begin
            chain_r <= {chain_r[NB_SYNC-2:0], d};
        end
    end

    assign q = chain_r[NB_SYNC-1];

endmodule

// File: rtl/mcp_rx_multibit.sv
// mcp_rx_multibit: destination-side receiver for a multibit word sent with
// the toggle req/ack multicycle-path scheme. The request toggle is
// synchronized, the word is captured on the resulting edge event and
// offered on a valid/ready interface; acceptance toggles the ack.
// Optional feature macro: MCP_RX_STABILITY_CHECK_EN adds a CHECK state
// that re-samples the bus until two consecutive samples agree.
module mcp_rx_multibit
    import mcp_rx_multibit_pkg::*;
#(
    parameter int NB      = 8,
    parameter int NB_SYNC = 2,
    parameter int NB_CNT  = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB-1:0]     i_data,
    input  logic              i_req,
    output logic              o_ack,
    output logic [NB-1:0]     o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overrun,
    output logic              o_unstable,
    output logic [NB_CNT-1:0] o_count
);

    if (NB_SYNC < MIN_NB_SYNC) begin : g_bad_sync_depth
        $error("mcp_rx_multibit: NB_SYNC must be at least 2");
    end

    state_t              state_r;
    state_t              next_state_s;
    logic                req_sync_s;
    logic                req_prev_r;
    logic                event_s;
    logic                capture_s;
    logic                accept_s;
    logic                overrun_set_s;
    logic                unstable_set_s;
    logic [NB-1:0]       data_r;
    logic                valid_r;
    logic                ack_r;
    logic                overrun_r;
    logic [NB_CNT-1:0]   count_r;

    sync_bit_chain #(
        .NB_SYNC (NB_SYNC)
    ) u_req_sync (
        .clock (i_clock),
        .reset (i_reset),
        .d     (i_req),
        .q     (req_sync_s)
    );

    // A toggle of the synchronized request marks a new word.
    assign event_s = req_sync_s ^ req_prev_r;

    // Next-state and datapath control decode.
    always_comb begin
        next_state_s   = state_r;
        capture_s      = 1'b0;
        accept_s       = 1'b0;
        overrun_set_s  = 1'b0;
        unstable_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (event_s) begin
                    capture_s = 1'b1;
`ifdef MCP_RX_STABILITY_CHECK_EN
                    next_state_s = ST_CHECK;
`else
                    next_state_s = ST_VALID;
`endif
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
`ifdef MCP_RX_STABILITY_CHECK_EN
            ST_CHECK: begin
                overrun_set_s = event_s;
                if (i_data == data_r) begin
                    next_state_s = ST_VALID;
                end else begin
                    capture_s      = 1'b1;
                    unstable_set_s = 1'b1;
                    next_state_s   = ST_CHECK;
                end
            end
`endif
            ST_VALID: begin
                overrun_set_s = event_s;
                if (i_ready) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_VALID;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, captured word, handshake and status registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            req_prev_r <= 1'b0;
            data_r     <= {NB{1'b0}};
            valid_r    <= 1'b0;
            ack_r      <= 1'b0;
            overrun_r  <= 1'b0;
            count_r    <= {NB_CNT{1'b0}};
        end else begin
            state_r    <= next_state_s;
            req_prev_r <= req_sync_s;
            valid_r    <= (next_state_s == ST_VALID);
            if (capture_s) begin
                data_r <= i_data;
            end
            if (accept_s) begin
                ack_r   <= ~ack_r;
                count_r <= count_r + {{(NB_CNT-1){1'b0}}, 1'b1};
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

`ifdef MCP_RX_STABILITY_CHECK_EN
    logic unstable_r;

    // Sticky flag: the bus moved while its stability was being checked.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            unstable_r <= 1'b0;
        end else if (unstable_set_s) begin
            unstable_r <= 1'b1;
        end else begin
            unstable_r <= unstable_r;
        end
    end

    assign o_unstable = unstable_r;
`else
    assign o_unstable = 1'b0;
`endif

    assign o_ack     = ack_r;
    assign o_data    = data_r;
    assign o_valid   = valid_r;
    assign o_overrun = overrun_r;
    assign o_count   = count_r;

endmodule

// File: tb/tb_mcp_rx_multibit.sv
// Self-checking bench for mcp_rx_multibit: a source model toggles the
// request, expected words go into a scoreboard queue and are popped when
// the DUT presents them. Works with and without MCP_RX_STABILITY_CHECK_EN.
module tb_mcp_rx_multibit;

    localparam int NB      = 8;
    localparam int NB_SYNC = 2;
    localparam int NB_CNT  = 4;
`ifdef MCP_RX_STABILITY_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif
    localparam int BASE_LAT = NB_SYNC + 1 + CHK_EN;

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic [NB-1:0]     i_data;
    logic              i_req;
    logic              o_ack;
    logic [NB-1:0]     o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_overrun;
    logic              o_unstable;
    logic [NB_CNT-1:0] o_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [NB-1:0]     exp_q[$];
    logic [NB_CNT-1:0] exp_count;
    logic              exp_ack;

    mcp_rx_multibit #(
        .NB      (NB),
        .NB_SYNC (NB_SYNC),
        .NB_CNT  (NB_CNT)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .i_req      (i_req),
        .o_ack      (o_ack),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overrun  (o_overrun),
        .o_unstable (o_unstable),
        .o_count    (o_count)
    );

    // Free-running destination clock.
    always #5 i_clock = ~i_clock;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_req   = 1'b0;
        i_ready = 1'b0;
        i_data  = 8'h00;
        repeat (3) tick();
        i_reset   = 1'b0;
        exp_count = 4'd0;
        exp_ack   = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_word(input logic [NB-1:0] d);
        i_data = d;
        i_req  = ~i_req;
    endtask

    // Wait for o_valid; cycle 1 is the first edge that samples the toggle.
    task automatic wait_valid(input string tag, input int exp_lat,
                              input bit do_switch, input logic [NB-1:0] alt);
        int cyc;
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (do_switch && c == NB_SYNC + 1) i_data = alt;
            if (o_valid) begin
                cyc = c;
                break;
            end
        end
        check_value({tag, "_latency"}, cyc, exp_lat);
    endtask

    // Hold i_ready low for 'hold' cycles, then accept and check the handshake.
    task automatic consume(input string tag, input int hold);
        logic [NB-1:0] exp_d;
        if (exp_q.size() == 0) begin
            check_value({tag, "_queue_empty"}, 32'd0, 32'd1);
            exp_d = 8'h00;
        end else begin
            exp_d = exp_q.pop_front();
        end
        check_value({tag, "_data"}, o_data, exp_d);
        for (int h = 0; h < hold; h++) begin
            i_ready = 1'b0;
            tick();
            check_value({tag, "_hold_valid"}, o_valid, 1'b1);
            check_value({tag, "_hold_data"}, o_data, exp_d);
            check_value({tag, "_hold_ack"}, o_ack, exp_ack);
        end
        i_ready = 1'b1;
        tick();
        exp_ack   = ~exp_ack;
        exp_count = exp_count + 4'd1;
        check_value({tag, "_valid_drop"}, o_valid, 1'b0);
        check_value({tag, "_ack"}, o_ack, exp_ack);
        check_value({tag, "_count"}, o_count, exp_count);
        i_ready = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int hold;
        logic [NB-1:0] d;

        do_reset();
        check_value("rst_valid", o_valid, 1'b0);
        check_value("rst_ack", o_ack, 1'b0);
        check_value("rst_count", o_count, 4'd0);
        check_value("rst_data", o_data, 8'h00);
        check_value("rst_overrun", o_overrun, 1'b0);
        check_value("rst_unstable", o_unstable, 1'b0);

        // First word with the consumer already ready: valid for one cycle.
        i_ready = 1'b1;
        start_word(8'hA5);
        exp_q.push_back(8'hA5);
        wait_valid("w1", BASE_LAT, 1'b0, 8'h00);
        consume("w1", 0);

        // Back-pressure for five cycles.
        start_word(8'h3C);
        exp_q.push_back(8'h3C);
        wait_valid("w2", BASE_LAT, 1'b0, 8'h00);
        consume("w2", 5);
        check_value("overrun_before", o_overrun, 1'b0);

        // Protocol violation: second toggle while the word is held.
        start_word(8'h77);
        exp_q.push_back(8'h77);
        wait_valid("ovr", BASE_LAT, 1'b0, 8'h00);
        start_word(8'h99);
        repeat (NB_SYNC + 1) tick();
        check_value("ovr_flag", o_overrun, 1'b1);
        check_value("ovr_valid", o_valid, 1'b1);
        check_value("ovr_held", o_data, 8'h77);
        consume("ovr", 0);
        repeat (4) tick();
        check_value("ovr_idle_valid", o_valid, 1'b0);
        check_value("ovr_one_word", o_count, exp_count);

        // Bus changes right after capture and then stays at the new value.
        i_ready = 1'b1;
        start_word(8'h0F);
        exp_q.push_back((CHK_EN != 0) ? 8'hF0 : 8'h0F);
        wait_valid("unst", BASE_LAT + CHK_EN, 1'b1, 8'hF0);
        consume("unst", 0);
        check_value("unst_flag", o_unstable, CHK_EN[0]);

        // Reset while a word is held.
        start_word(8'h5A);
        wait_valid("rv", BASE_LAT, 1'b0, 8'h00);
        check_value("rv_overrun_pre", o_overrun, 1'b1);
        i_reset = 1'b1;
        i_req   = 1'b0;
        tick();
        i_reset = 1'b0;
        exp_count = 4'd0;
        exp_ack   = 1'b0;
        check_value("rv_valid", o_valid, 1'b0);
        check_value("rv_ack", o_ack, 1'b0);
        check_value("rv_count", o_count, 4'd0);
        check_value("rv_data", o_data, 8'h00);
        check_value("rv_overrun", o_overrun, 1'b0);
        check_value("rv_unstable", o_unstable, 1'b0);
        repeat (3) tick();

        // Seventeen words: counter wraps to 1, order preserved.
        for (int n = 0; n < 17; n++) begin
            hold = $urandom_range(0, 2);
            d = NB'($urandom);
            i_ready = (hold == 0);
            start_word(d);
            exp_q.push_back(d);
            wait_valid("wrap", BASE_LAT, 1'b0, 8'h00);
            consume("wrap", hold);
        end
        check_value("wrap_final_count", o_count, 4'd1);
        check_value("wrap_queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
